// File: rtl/jk_state_decoder.sv
// Observer/decoder for the two-flip-flop JK machine (A+ = x, B+ = B ^ (~A & x)).
// It recovers x from each {A,B} transition, flags illegal B moves, and packs bits MSB-first into WIDTH-bit words.
// Optional saturating error counter: define JKDEC_ERRCNT_EN.
//
// Handshake: a word is offered while word_vld=1. It is consumed on any rising
// Clk edge with word_vld=1 and out_ready=1. word is held stable until then.
module jk_state_decoder #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             en,
  input  logic             sync,
  input  logic             out_ready,
  output logic             x_rec,
  output logic             x_vld,
  output logic             err,
  output logic [WIDTH-1:0] word,
  output logic             word_vld,
  output logic             overrun,
  output logic             dbg_state
`ifdef JKDEC_ERRCNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, TRACK = 1'b1} state_t;

  state_t           state;
  logic             prev_a;
  logic             prev_b;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] asm_reg;

  logic             sample;
  logic             exp_b;
  logic             bit_err;
  logic             last_bit;
  logic             complete;
  logic             accept;
  logic [WIDTH-1:0] next_asm;

  // A sample only decodes a bit when a previous sample is already held.
  assign sample    = en & ~sync & (state == TRACK);
  assign exp_b     = prev_b ^ (~prev_a & A);
  assign bit_err   = (B != exp_b);
  assign last_bit  = (bit_cnt == CW'(WIDTH - 1));
  assign complete  = sample & last_bit;
  assign accept    = word_vld & out_ready;
  assign next_asm  = {asm_reg[WIDTH-2:0], A};
  assign dbg_state = state;

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      prev_a   <= 1'b0;
      prev_b   <= 1'b0;
      x_rec    <= 1'b0;
      x_vld    <= 1'b0;
      err      <= 1'b0;
      word     <= '0;
      word_vld <= 1'b0;
      overrun  <= 1'b0;
      bit_cnt  <= '0;
      asm_reg  <= '0;
    end else begin
      x_vld <= 1'b0;
      err   <= 1'b0;

      if (sync) begin
        state   <= IDLE;
        bit_cnt <= '0;
        asm_reg <= '0;
      end else if (en) begin
        prev_a <= A;
        prev_b <= B;
        if (state == IDLE) begin
          state <= TRACK;
        end else begin
          x_rec   <= A;
          x_vld   <= 1'b1;
          err     <= bit_err;
          asm_reg <= next_asm;
          bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        end
      end

      // A completion that coincides with acceptance reloads and keeps word_vld high.
      if (complete) begin
        if (!word_vld || out_ready) begin
          word     <= next_asm;
          word_vld <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (accept) begin
        word_vld <= 1'b0;
      end
    end
  end

`ifdef JKDEC_ERRCNT_EN
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= 8'h00;
    end else if (sample && bit_err && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_jk_state_decoder.sv
// Directed bench for jk_state_decoder (WIDTH=8): legal/illegal transitions, packing,
// overrun, resync and asynchronous reset. The err_cnt checks are built with JKDEC_ERRCNT_EN.
module tb_jk_state_decoder;

  logic       Clk = 1'b0;
  logic       rst = 1'b0;
  logic       A = 1'b0;
  logic       B = 1'b0;
  logic       en = 1'b0;
  logic       sync = 1'b0;
  logic       out_ready = 1'b0;
  logic       x_rec;
  logic       x_vld;
  logic       err;
  logic [7:0] word;
  logic       word_vld;
  logic       overrun;
  logic       dbg_state;
`ifdef JKDEC_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference JK machine driving A/B.
  logic jk_a = 1'b0;
  logic jk_b = 1'b0;

  jk_state_decoder #(.WIDTH(8)) dut (
    .Clk       (Clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .en        (en),
    .sync      (sync),
    .out_ready (out_ready),
    .x_rec     (x_rec),
    .x_vld     (x_vld),
    .err       (err),
    .word      (word),
    .word_vld  (word_vld),
    .overrun   (overrun),
    .dbg_state (dbg_state)
`ifdef JKDEC_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  // Drive one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic step(input logic a, input logic b, input logic e, input logic s, input logic r);
    A = a; B = b; en = e; sync = s; out_ready = r;
    @(posedge Clk);
    #1;
  endtask

  // Advance the reference JK machine with input x and present its new state.
  task automatic feed(input logic x, input logic r);
    jk_b = jk_b ^ (~jk_a & x);
    jk_a = x;
    step(jk_a, jk_b, 1'b1, 1'b0, r);
  endtask

  task automatic feed_byte(input logic [7:0] w, input logic r);
    for (int i = 7; i >= 0; i--) feed(w[i], r);
  endtask

  task automatic do_reset();
    rst = 1'b0; A = 1'b0; B = 1'b0; en = 1'b0; sync = 1'b0; out_ready = 1'b0;
    jk_a = 1'b0; jk_b = 1'b0;
    @(posedge Clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    n_checks++;
    if ({x_rec, x_vld, err, word, word_vld, overrun, dbg_state} !== 14'h0) begin
      $display("FAIL reset_outputs: got %b, want all 0", {x_rec, x_vld, err, word, word_vld, overrun, dbg_state});
      n_fail++;
    end
`ifdef JKDEC_ERRCNT_EN
    n_checks++;
    if (err_cnt !== 8'h00) begin $display("FAIL reset_err_cnt: got %h want 00", err_cnt); n_fail++; end
`endif
    do_reset();
  endtask

  task automatic test_legal();
    logic [1:0] seq [5];
    logic       exp_x [4];
    seq[0] = 2'b00; seq[1] = 2'b11; seq[2] = 2'b11; seq[3] = 2'b01; seq[4] = 2'b10;
    exp_x[0] = 1'b1; exp_x[1] = 1'b1; exp_x[2] = 1'b0; exp_x[3] = 1'b1;
    do_reset();
    step(seq[0][1], seq[0][0], 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (x_vld !== 1'b0 || dbg_state !== 1'b1) begin
      $display("FAIL legal_prime: x_vld=%b state=%b, want x_vld=0 state=1", x_vld, dbg_state);
      n_fail++;
    end
    for (int i = 1; i < 5; i++) begin
      step(seq[i][1], seq[i][0], 1'b1, 1'b0, 1'b1);
      n_checks++;
      if (x_vld !== 1'b1 || x_rec !== exp_x[i-1] || err !== 1'b0) begin
        $display("FAIL legal_bit%0d: x_vld=%b x_rec=%b err=%b, want 1 %b 0", i, x_vld, x_rec, err, exp_x[i-1]);
        n_fail++;
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (x_vld !== 1'b0 || err !== 1'b0) begin
      $display("FAIL legal_idle_en0: x_vld=%b err=%b, want 0 0", x_vld, err);
      n_fail++;
    end
  endtask

  task automatic test_illegal();
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (err !== 1'b1 || x_vld !== 1'b1 || x_rec !== 1'b0) begin
      $display("FAIL illegal_err: err=%b x_vld=%b x_rec=%b, want 1 1 0", err, x_vld, x_rec);
      n_fail++;
    end
`ifdef JKDEC_ERRCNT_EN
    n_checks++;
    if (err_cnt !== 8'h01) begin $display("FAIL illegal_err_cnt: got %h want 01", err_cnt); n_fail++; end
`endif
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (err !== 1'b0) begin $display("FAIL illegal_pulse_width: err=%b want 0", err); n_fail++; end
  endtask

  task automatic test_packing();
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    feed_byte(8'b1011_0010, 1'b0);
    n_checks++;
    if (word_vld !== 1'b1 || word !== 8'hB2) begin
      $display("FAIL pack_word: word_vld=%b word=%h, want 1 b2", word_vld, word);
      n_fail++;
    end
    step(jk_a, jk_b, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (word_vld !== 1'b1 || word !== 8'hB2) begin
      $display("FAIL pack_hold: word_vld=%b word=%h, want 1 b2", word_vld, word);
      n_fail++;
    end
    step(jk_a, jk_b, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (word_vld !== 1'b0) begin $display("FAIL pack_accept: word_vld=%b want 0", word_vld); n_fail++; end
  endtask

  task automatic test_overrun();
    logic [7:0] w3;
    w3 = 8'h96;
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    feed_byte(8'hA5, 1'b0);
    n_checks++;
    if (word !== 8'hA5 || word_vld !== 1'b1 || overrun !== 1'b0) begin
      $display("FAIL ovr_first: word=%h vld=%b ovr=%b, want a5 1 0", word, word_vld, overrun);
      n_fail++;
    end
    feed_byte(8'h3C, 1'b0);
    n_checks++;
    if (word !== 8'hA5 || word_vld !== 1'b1 || overrun !== 1'b1) begin
      $display("FAIL ovr_second: word=%h vld=%b ovr=%b, want a5 1 1", word, word_vld, overrun);
      n_fail++;
    end
    for (int i = 7; i >= 1; i--) feed(w3[i], 1'b0);
    feed(w3[0], 1'b1);
    n_checks++;
    if (word !== 8'h96 || word_vld !== 1'b1 || overrun !== 1'b1) begin
      $display("FAIL ovr_third: word=%h vld=%b ovr=%b, want 96 1 1", word, word_vld, overrun);
      n_fail++;
    end
    step(jk_a, jk_b, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (word_vld !== 1'b0 || overrun !== 1'b1) begin
      $display("FAIL ovr_sticky: vld=%b ovr=%b, want 0 1", word_vld, overrun);
      n_fail++;
    end
  endtask

  task automatic test_resync();
    logic [7:0] w;
    w = 8'h69;
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    feed(1'b1, 1'b1); feed(1'b0, 1'b1); feed(1'b1, 1'b1);
    step(jk_a, jk_b, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (x_vld !== 1'b0 || dbg_state !== 1'b0) begin
      $display("FAIL sync_cycle: x_vld=%b state=%b, want 0 0", x_vld, dbg_state);
      n_fail++;
    end
    step(jk_a, jk_b, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (x_vld !== 1'b0 || dbg_state !== 1'b1) begin
      $display("FAIL sync_reprime: x_vld=%b state=%b, want 0 1", x_vld, dbg_state);
      n_fail++;
    end
    for (int i = 7; i >= 1; i--) feed(w[i], 1'b0);
    n_checks++;
    if (word_vld !== 1'b0) begin $display("FAIL sync_early_word: word_vld=%b want 0", word_vld); n_fail++; end
    feed(w[0], 1'b0);
    n_checks++;
    if (word_vld !== 1'b1 || word !== 8'h69) begin
      $display("FAIL sync_word: vld=%b word=%h, want 1 69", word_vld, word);
      n_fail++;
    end
    feed(1'b1, 1'b0); feed(1'b1, 1'b0);
    n_checks++;
    if (x_vld !== 1'b1 || x_rec !== 1'b1 || word_vld !== 1'b1) begin
      $display("FAIL pre_rst_state: x_vld=%b x_rec=%b vld=%b, want 1 1 1", x_vld, x_rec, word_vld);
      n_fail++;
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({x_rec, x_vld, err, word, word_vld, overrun, dbg_state} !== 14'h0) begin
      $display("FAIL async_reset: got %b, want all 0", {x_rec, x_vld, err, word, word_vld, overrun, dbg_state});
      n_fail++;
    end
    @(posedge Clk);
    #1;
    rst = 1'b1;
  endtask

`ifdef JKDEC_ERRCNT_EN
  task automatic test_saturation();
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    // Alternating 01/00 violates the B rule on every sample.
    for (int i = 0; i < 300; i++) step(1'b0, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (err_cnt !== 8'hFF) begin $display("FAIL sat_err_cnt: got %h want ff", err_cnt); n_fail++; end
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (err_cnt !== 8'hFF || err !== 1'b1) begin
      $display("FAIL sat_no_wrap: err_cnt=%h err=%b, want ff 1", err_cnt, err);
      n_fail++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_legal();
    test_illegal();
    test_packing();
    test_overrun();
    test_resync();
`ifdef JKDEC_ERRCNT_EN
    test_saturation();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_state_decoder.md
# jk_state_decoder

Receive-side decoder for the two-flip-flop JK state machine (next-state rules A+ = x, B+ = B ^ (~A & x)). It samples the machine's state pair {A,B} each enabled clock, recovers the input bit x that caused each transition, and checks every transition against the B rule. Recovered bits are packed MSB-first into WIDTH-bit words and delivered through a valid/ready handshake. It sits beside the JK machine on the same Clk and rst, as its observer and decoder.

## Interface
- WIDTH, 8, bits per packed output word (2..16)
- Clk  input  1  clock; all state changes occur on the rising edge
- rst  input  1  asynchronous, active-low reset
- A  input  1  state bit A from the JK machine
- B  input  1  state bit B from the JK machine
- en  input  1  sample enable; {A,B} is consumed only on edges where en=1
- sync  input  1  synchronous resynchronise; has priority over en
- out_ready  input  1  consumer accepts word
- x_rec  output  1  last recovered bit
- x_vld  output  1  one-cycle pulse; x_rec is new
- err  output  1  one-cycle pulse; illegal B transition detected
- word  output  WIDTH  packed recovered bits, MSB = oldest
- word_vld  output  1  word holds an unaccepted word
- overrun  output  1  sticky; a completed word was dropped
- err_cnt  output  8  saturating error count (present only with JKDEC_ERRCNT_EN)

## Operation
- Two states, encoded as one bit:
  - IDLE: no previous sample is held.
  - TRACK: prevA/prevB are valid.
- IDLE, en=1: latch prevA=A, prevB=B. Go to TRACK. No x_vld.
- TRACK, en=1:
  - Recovered bit = A.
  - Expected B = prevB ^ (~prevA & A).
  - Pulse x_vld with x_rec=A.
  - Pulse err if B != expected B. The bit is still recovered and packed.
  - Update prevA/prevB to the current A/B.
- Packing:
  - Assembly register shifts in each recovered bit: asm <= {asm[WIDTH-2:0], bit}.
  - bit_cnt counts 0..WIDTH-1.
  - On the WIDTH-th bit, bit_cnt wraps to 0 and the completed word is offered to the output register.
- Output register transfer:
  - The completed word loads into word, and word_vld sets, if word_vld=0 or out_ready=1 in the same cycle.
  - Otherwise the completed word is dropped and overrun sets.
- Handshake:
  - A word is accepted on an edge where word_vld=1 and out_ready=1; word_vld then clears.
  - If a completion coincides with acceptance, the new word loads and word_vld stays 1.
- sync=1: go to IDLE and clear bit_cnt and asm.
  - word, word_vld, overrun and err_cnt are unaffected.
  - x_vld and err are 0 that cycle.
- en=0 and sync=0: state and prev registers hold. Pulses are 0. The handshake still operates.

## Timing
- Reset (rst=0): state=IDLE, prevA=prevB=0, x_rec=0, x_vld=0, err=0, word=0, word_vld=0, overrun=0, bit_cnt=0, asm=0, err_cnt=0.
- Reset applied mid-word discards the partial word immediately, without waiting for a clock edge.
- All outputs are registered.
- x_vld and err assert for exactly one cycle after the sampling edge.
- Latency: x applied to the JK machine at edge k appears as A after edge k. The decoder samples it at edge k+1 and presents x_rec after edge k+1.
- word_vld rises after the edge that samples the WIDTH-th bit.
- word is stable while word_vld=1 and out_ready=0.
- overrun is cleared only by rst.

## Configuration
- JKDEC_ERRCNT_EN defined:
  - err_cnt port exists.
  - It increments on each err pulse and saturates at 8'hFF.
  - It is cleared only by rst.
- JKDEC_ERRCNT_EN undefined:
  - err_cnt port and counter are absent.
  - All other behaviour is identical.

## Test plan
- Legal sequence: reset, then en=1 with sync=0 and out_ready=1, feeding {A,B} = 00,11,11,01,10.
  - Required: x_rec pulses 1,1,0,1.
  - Required: err never asserts.
- Illegal transition: {A,B} = 00 then 01.
  - Required: one err pulse with x_rec=0.
  - With JKDEC_ERRCNT_EN: err_cnt=1.
- Packing: WIDTH=8, recovered bits 1,0,1,1,0,0,1,0.
  - Required: word=8'hB2 and word_vld=1 one cycle after the eighth sample.
  - Required: word_vld clears after the out_ready edge.
- Overrun: out_ready=0 across two complete words.
  - Required: first word holds, overrun=1, second word dropped.
  - Then assert out_ready=1 in the same cycle the third word completes. Required: the third word loads and word_vld stays 1.
- Resync/reset: sync=1 after 3 bits.
  - Required: the next en sample gives no x_vld.
  - Required: a new word needs 8 further recovered bits.
  - Then assert rst=0 mid-word. Required: all outputs are 0 immediately.
- Saturation (JKDEC_ERRCNT_EN): 300 illegal transitions.
  - Required: err_cnt=8'hFF and it does not wrap.
